// File: rtl/dct2_1d_row_sched_if.sv
// Row-scheduler bus bundle: block config, input row stream, core drive/return,
// output row stream and status.
//   master : the scheduler side (drives cfg_ready, in_ready, core_x/core_n,
//            out_* and busy)
//   slave  : the environment side (offers configs and rows, evaluates the core,
//            accepts output rows)
interface dct2_1d_row_sched_if #(
   parameter int W     = 16,
   parameter int LANES = 32
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [1:0]           cfg_size;
   logic                 in_valid;
   logic                 in_ready;
   logic [W*LANES-1:0]   in_data;
   logic [W*LANES-1:0]   core_x;
   logic [1:0]           core_n;
   logic [W*LANES-1:0]   core_y;
   logic                 out_valid;
   logic                 out_ready;
   logic [W*LANES-1:0]   out_data;
   logic [4:0]           out_row;
   logic                 out_last;
   logic                 busy;

   modport master (
      input  cfg_valid, cfg_size, in_valid, in_data, core_y, out_ready,
      output cfg_ready, in_ready, core_x, core_n, out_valid, out_data,
             out_row, out_last, busy
   );

   modport slave (
      output cfg_valid, cfg_size, in_valid, in_data, core_y, out_ready,
      input  cfg_ready, in_ready, core_x, core_n, out_valid, out_data,
             out_row, out_last, busy
   );
endinterface

// File: rtl/dct2_1d_row_sched.sv
// Row scheduler / pipeline controller for the combinational 1-D DCT-II core.
// Accepts a block size, streams 4/8/16/32 rows through the core in a two-stage
// registered pipeline (S1 = core input, S2 = core output) and frames the output
// with a row index and a last flag.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous abort, highest priority; clears valids, counters, state
//   bus    dct2_1d_row_sched_if.master (config, in/out row streams, core drive)
//
// state  | meaning
// IDLE   | waiting for a block config; cfg_ready=1, core_n may change
// RUN    | accepting rows of the current block
// DRAIN  | all rows accepted; waiting for the last output handshake
module dct2_1d_row_sched #(
   parameter int W     = 16,
   parameter int LANES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   dct2_1d_row_sched_if.master bus
);
   localparam int BW = W * LANES;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    state;
   logic [1:0]    size;
   logic [5:0]    rows;
   logic [4:0]    rows_m1;
   logic [4:0]    in_cnt;
   logic [4:0]    out_cnt;

   logic [BW-1:0] x_reg;
   logic          s1_valid;
   logic [4:0]    s1_row;

   logic [BW-1:0] y_reg;
   logic          out_valid_r;
   logic [4:0]    out_row_r;
   logic          out_last_r;

   logic [BW-1:0] x_masked;
   logic [BW-1:0] y_masked;

   logic          s2_ready;
   logic          adv;
   logic          in_ready_c;
   logic          cfg_hs;
   logic          in_hs;
   logic          out_hs;

   assign rows    = 6'd4 << size;
   assign rows_m1 = 5'(rows - 6'd1);

   // Lanes beyond the block size carry no transform data; zero them on both
   // captures so stale or garbage lanes never reach the core or downstream.
   always_comb begin
      x_masked = '0;
      y_masked = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(rows)) begin
            x_masked[i*W +: W] = bus.in_data[i*W +: W];
            y_masked[i*W +: W] = bus.core_y[i*W +: W];
         end
      end
   end

   assign s2_ready   = !out_valid_r || bus.out_ready;
   assign in_ready_c = (state == ST_RUN) && (!s1_valid || s2_ready);

   // flush blocks every handshake in its cycle
   assign cfg_hs = bus.cfg_valid && (state == ST_IDLE) && !flush;
   assign in_hs  = bus.in_valid && in_ready_c && !flush;
   assign out_hs = out_valid_r && bus.out_ready && !flush;
   assign adv    = s1_valid && s2_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         size    <= 2'b00;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (flush) begin
         state   <= ST_IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_hs) begin
                  size    <= bus.cfg_size;
                  in_cnt  <= '0;
                  out_cnt <= '0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (in_hs) begin
                  in_cnt <= in_cnt + 5'd1;
                  if (in_cnt == rows_m1)
                     state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (out_hs && (out_cnt == rows_m1))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         // the final output of a block cannot complete before DRAIN, so no
         // output handshake ever coincides with the IDLE counter clear
         if (out_hs)
            out_cnt <= out_cnt + 5'd1;
      end
   end

   // S1: new row wins over advance; when both happen the pipeline shifts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg    <= '0;
         s1_valid <= 1'b0;
         s1_row   <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (in_hs) begin
         x_reg    <= x_masked;
         s1_valid <= 1'b1;
         s1_row   <= in_cnt;
      end else if (adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2: holds data steady while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg       <= '0;
         out_valid_r <= 1'b0;
         out_row_r   <= '0;
         out_last_r  <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else if (adv) begin
         y_reg       <= y_masked;
         out_valid_r <= 1'b1;
         out_row_r   <= s1_row;
         out_last_r  <= (s1_row == rows_m1);
      end else if (out_hs) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end
   end

   assign bus.cfg_ready = (state == ST_IDLE);
   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.core_x    = x_reg;
   assign bus.core_n    = size;
   assign bus.out_data  = y_reg;
   assign bus.out_valid = out_valid_r;
   assign bus.out_row   = out_row_r;
   assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_dct2_1d_row_sched.sv
module tb_dct2_1d_row_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   dct2_1d_row_sched_if #(.W(16), .LANES(32)) bus ();

   dct2_1d_row_sched #(.W(16), .LANES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Stand-in for the DCT core: every output lane is a weighted sum of all
   // 32 input lanes, with weights that depend on N, so unmasked lanes or a
   // wrong core_n change the result.
   function automatic logic [511:0] core_fn(input logic [511:0] x, input logic [1:0] n);
      logic [511:0] y;
      int acc;
      int w;
      y = '0;
      for (int k = 0; k < 32; k++) begin
         acc = 0;
         for (int j = 0; j < 32; j++) begin
            w = ((k * (2 * j + 1) + 3 * int'(n)) % 7) - 3;
            acc += int'($signed(x[j*16 +: 16])) * w;
         end
         y[k*16 +: 16] = acc[15:0];
      end
      return y;
   endfunction

   always_comb bus.core_y = core_fn(bus.core_x, bus.core_n);

   // Reference: only the first N lanes of a row exist, in and out.
   function automatic logic [511:0] ref_row(input logic [511:0] x, input logic [1:0] s);
      int nrows;
      logic [511:0] xm;
      logic [511:0] y;
      logic [511:0] ym;
      nrows = 4 << s;
      xm = '0;
      ym = '0;
      for (int i = 0; i < nrows; i++) xm[i*16 +: 16] = x[i*16 +: 16];
      y = core_fn(xm, s);
      for (int i = 0; i < nrows; i++) ym[i*16 +: 16] = y[i*16 +: 16];
      return ym;
   endfunction

   typedef struct {
      logic [511:0] data;
      logic [4:0]   row;
      logic         last;
      logic [1:0]   size;
      int           in_cyc;
   } exp_t;

   exp_t q[$];
   logic [1:0] cur_size = 2'b00;
   int blk_in = 0;
   int last_out_cyc = 0;
   bit lat_chk = 0;
   int sim_cnt = 0;
   bit prev_stall = 0;
   logic [511:0] prev_data;
   logic [4:0] prev_row;

   // scoreboard monitor: pushes on input handshakes, pops on output ones
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (!rst_n) begin
         q.delete();
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 512'(bus.out_valid), 512'(1));
            chk("stall_data", bus.out_data, prev_data);
            chk("stall_row", 512'(bus.out_row), 512'(prev_row));
         end
         if (q.size() == 2 && !bus.out_ready)
            chk("full_in_ready", 512'(bus.in_ready), 512'(0));
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() == 2 && bus.in_valid && bus.in_ready && bus.out_valid && bus.out_ready)
               sim_cnt++;
            if (bus.out_valid && bus.out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_out", 512'(bus.out_row), 512'(32'hffff_ffff));
               end else begin
                  got = q.pop_front();
                  chk("out_data", bus.out_data, got.data);
                  chk("out_row", 512'(bus.out_row), 512'(got.row));
                  chk("out_last", 512'(bus.out_last), 512'(got.last));
                  chk("core_n", 512'(bus.core_n), 512'(got.size));
                  if (lat_chk) chk("latency", 512'(cyc - got.in_cyc), 512'(2));
               end
               last_out_cyc = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
               e.data = ref_row(bus.in_data, cur_size);
               e.row = 5'(blk_in);
               e.last = (blk_in == (4 << cur_size) - 1);
               e.size = cur_size;
               e.in_cyc = cyc;
               q.push_back(e);
               blk_in++;
            end
            if (bus.cfg_valid && bus.cfg_ready) begin
               cur_size = bus.cfg_size;
               blk_in = 0;
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready && !flush;
         prev_data = bus.out_data;
         prev_row = bus.out_row;
      end
   end

   // out_ready: 0 = always 1, 1 = random 50%, 2 = held 0
   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: bus.out_ready = 1'($urandom_range(0, 1));
         2: bus.out_ready = 1'b0;
         default: bus.out_ready = 1'b1;
      endcase
   end

   function automatic logic [511:0] rand_row();
      logic [511:0] r;
      for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'($urandom);
      return r;
   endfunction

   task automatic do_cfg(input logic [1:0] s, output int seen);
      bit ok;
      ok = 0;
      seen = 0;
      bus.cfg_valid = 1'b1;
      bus.cfg_size = s;
      for (int c = 0; c < 500 && !ok; c++) begin
         @(negedge clk);
         if (bus.cfg_ready && !flush) begin
            ok = 1;
            seen = cyc;
         end
      end
      if (!ok) chk("cfg_timeout", 512'(0), 512'(1));
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic send_rows(input int n, input bit pat);
      bit ok;
      logic [511:0] r;
      for (int k = 0; k < n; k++) begin
         r = rand_row();
         if (pat) for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'h0040;
         bus.in_valid = 1'b1;
         bus.in_data = r;
         ok = 0;
         for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready && !flush) ok = 1;
         end
         if (!ok) chk("in_timeout", 512'(0), 512'(1));
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         if (!bus.busy && q.size() == 0) ok = 1;
      end
      chk(nm, 512'(ok), 512'(1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cfg_ready"}, 512'(bus.cfg_ready), 512'(1));
      chk({tag, "_in_ready"}, 512'(bus.in_ready), 512'(0));
      chk({tag, "_busy"}, 512'(bus.busy), 512'(0));
      chk({tag, "_out_valid"}, 512'(bus.out_valid), 512'(0));
      chk({tag, "_out_last"}, 512'(bus.out_last), 512'(0));
      chk({tag, "_out_row"}, 512'(bus.out_row), 512'(0));
      chk({tag, "_out_data"}, bus.out_data, 512'(0));
      chk({tag, "_core_x"}, bus.core_x, 512'(0));
      chk({tag, "_core_n"}, 512'(bus.core_n), 512'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      bit ok;
      bus.cfg_valid = 1'b0;
      bus.cfg_size = 2'b00;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      #12;
      chk_reset_vals("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // size 4, out_ready high: latency, framing, return to IDLE
      rdy_mode = 0;
      lat_chk = 1;
      do_cfg(2'b00, seen);
      send_rows(4, 1'b1);
      ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (bus.cfg_ready) ok = 1;
      end
      chk("s4_cfg_ready", 512'(ok), 512'(1));
      chk("s4_cfg_ready_delay", 512'(cyc - last_out_cyc), 512'(1));
      chk("s4_sb_empty", 512'(q.size()), 512'(0));
      lat_chk = 0;
      @(posedge clk);
      #1;

      // size 32, random backpressure
      rdy_mode = 1;
      do_cfg(2'b11, seen);
      send_rows(32, 1'b0);
      wait_idle("s32_done");
      @(posedge clk);
      #1;

      // back-to-back blocks: 8 rows then 16 rows
      rdy_mode = 0;
      do_cfg(2'b01, seen);
      send_rows(8, 1'b0);
      do_cfg(2'b10, seen);
      chk("b2b_cfg_gap", 512'(seen - last_out_cyc), 512'(1));
      rdy_mode = 1;
      send_rows(16, 1'b0);
      wait_idle("b2b_done");
      @(posedge clk);
      #1;

      // flush mid-block with output valid
      rdy_mode = 0;
      do_cfg(2'b10, seen);
      send_rows(6, 1'b0);
      @(negedge clk);
      chk("fl_pre_valid", 512'(bus.out_valid), 512'(1));
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("fl_out_valid", 512'(bus.out_valid), 512'(0));
      chk("fl_busy", 512'(bus.busy), 512'(0));
      chk("fl_cfg_ready", 512'(bus.cfg_ready), 512'(1));
      chk("fl_out_last", 512'(bus.out_last), 512'(0));
      @(posedge clk);
      #1;
      do_cfg(2'b00, seen);
      send_rows(4, 1'b0);
      wait_idle("fl_new_block");
      @(posedge clk);
      #1;

      // simultaneous handshakes with both stages full
      rdy_mode = 1;
      sim_cnt = 0;
      do_cfg(2'b11, seen);
      send_rows(32, 1'b0);
      wait_idle("sim_done");
      chk("sim_seen", 512'(sim_cnt > 0), 512'(1));
      @(posedge clk);
      #1;

      // asynchronous reset with rows in flight
      rdy_mode = 2;
      do_cfg(2'b11, seen);
      send_rows(2, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      rdy_mode = 0;
      @(negedge clk);
      @(negedge clk);
      chk("arst_idle_cfg", 512'(bus.cfg_ready), 512'(1));
      chk("arst_idle_busy", 512'(bus.busy), 512'(0));
      chk("arst_idle_valid", 512'(bus.out_valid), 512'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
